fifo_256x8_sync: RTL and testbench

FIFO_256X8_SYNC -- requirements
Module: fifo_256x8_sync

---
 rtl/fifo_256x8_sync.sv | 57 +++++
 tb/tb_fifo_256x8_sync.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fifo_256x8_sync.sv
// fifo_256x8_sync: 256x8 synchronous FIFO, registered read data one edge after the pop, threshold flag.
module fifo_256x8_sync #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter logic [7:0] THRESHOLD = 8'd128
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             WRB,
  input  logic             RDB,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             GEQTH
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d, pend_addr_q, pend_addr_d;
  logic pend_q, pend_d, wr_en, rd_en;
  logic [WIDTH-1:0] dout_q, dout_d;
  assign FULL = cnt_q == AW'(DEPTH - 1);
  assign EMPTY = cnt_q == '0;
  assign GEQTH = cnt_q >= AW'(THRESHOLD);
  assign DATA_OUT = dout_q;
  assign wr_en = !WRB && !FULL;
  assign rd_en = !RDB && !EMPTY;
  // the popped slot cannot be rewritten before the next edge, since wr_ptr == rd_ptr only when empty
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + AW'(wr_en) - AW'(rd_en);
    pend_d = rd_en;
    pend_addr_d = rd_en ? rd_ptr_q : pend_addr_q;
    dout_d = pend_q ? mem_q[pend_addr_q] : dout_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
      dout_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pend_addr_q <= pend_addr_d;
      dout_q <= dout_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET && wr_en) mem_q[wr_ptr_q] <= DATA_IN;
  end
endmodule

// File: tb/tb_fifo_256x8_sync.sv
// tb_fifo_256x8_sync: directed checks of fill/drain order, flags, wrap, empty reads and reset.
module tb_fifo_256x8_sync;
  logic CLK = 1'b0, RESET, WRB, RDB;
  logic [7:0] DATA_IN, DATA_OUT;
  logic FULL, EMPTY, GEQTH;
  int nchk = 0, nerr = 0;

  fifo_256x8_sync dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .WRB(WRB), .RDB(RDB),
    .DATA_OUT(DATA_OUT), .FULL(FULL), .EMPTY(EMPTY), .GEQTH(GEQTH)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; WRB = 1'b1; RDB = 1'b1; DATA_IN = 8'h00;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_empty", 8'(EMPTY), 8'd1);
    chk("rst_full", 8'(FULL), 8'd0);
    chk("rst_geqth", 8'(GEQTH), 8'd0);
    chk("rst_dout", DATA_OUT, 8'h00);
    // single word round trip
    DATA_IN = 8'hA5; WRB = 1'b0; tick(); WRB = 1'b1;
    chk("wr1_empty", 8'(EMPTY), 8'd0);
    tick();
    RDB = 1'b0; tick(); RDB = 1'b1;
    chk("rd1_empty", 8'(EMPTY), 8'd1);
    chk("rd1_dout_early", DATA_OUT, 8'h00);
    tick();
    chk("rd1_dout", DATA_OUT, 8'hA5);
    // reads while empty
    RDB = 1'b0; tick(); tick(); RDB = 1'b1;
    chk("erd_dout", DATA_OUT, 8'hA5);
    chk("erd_empty", 8'(EMPTY), 8'd1);
    tick();
    chk("erd_dout2", DATA_OUT, 8'hA5);
    // fill to 255
    WRB = 1'b0;
    for (int i = 0; i < 255; i++) begin
      DATA_IN = 8'(i); tick();
      if (i == 126) chk("geqth_127", 8'(GEQTH), 8'd0);
      if (i == 127) chk("geqth_128", 8'(GEQTH), 8'd1);
      if (i == 253) chk("full_254", 8'(FULL), 8'd0);
    end
    chk("full_255", 8'(FULL), 8'd1);
    DATA_IN = 8'hFF; tick(); WRB = 1'b1;
    chk("full_ovf", 8'(FULL), 8'd1);
    // drain 255 in order
    RDB = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i == 0) chk("full_after_rd", 8'(FULL), 8'd0);
      if (i > 0) chk("drain_dout", DATA_OUT, 8'(i - 1));
    end
    RDB = 1'b1;
    chk("drain_empty", 8'(EMPTY), 8'd1);
    tick();
    chk("drain_last", DATA_OUT, 8'hFE);
    // move both pointers near the top of the RAM
    WRB = 1'b0;
    for (int i = 0; i < 250; i++) begin DATA_IN = 8'(i); tick(); end
    WRB = 1'b1; RDB = 1'b0;
    for (int i = 0; i < 250; i++) tick();
    RDB = 1'b1;
    chk("filler_empty", 8'(EMPTY), 8'd1);
    // 10 stored, then simultaneous read+write across the wrap
    WRB = 1'b0;
    for (int i = 0; i < 10; i++) begin DATA_IN = 8'h40 + 8'(i); tick(); end
    RDB = 1'b0;
    for (int k = 0; k < 20; k++) begin
      DATA_IN = 8'h4A + 8'(k); tick();
      if (k > 0) chk("rw_dout", DATA_OUT, 8'h40 + 8'(k - 1));
    end
    WRB = 1'b1; RDB = 1'b1; tick();
    chk("rw_last", DATA_OUT, 8'h53);
    RDB = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 8) chk("rw_cnt_not_empty", 8'(EMPTY), 8'd0);
      if (i > 0) chk("rw_tail_dout", DATA_OUT, 8'h54 + 8'(i - 1));
    end
    RDB = 1'b1;
    chk("rw_cnt_empty", 8'(EMPTY), 8'd1);
    tick();
    chk("rw_tail_last", DATA_OUT, 8'h5D);
    // reset with 50 stored and a read in flight
    WRB = 1'b0;
    for (int i = 0; i < 50; i++) begin DATA_IN = 8'h80 + 8'(i); tick(); end
    WRB = 1'b1;
    chk("fifty_empty", 8'(EMPTY), 8'd0);
    RDB = 1'b0; tick(); RDB = 1'b1;
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("mrst_empty", 8'(EMPTY), 8'd1);
    chk("mrst_full", 8'(FULL), 8'd0);
    chk("mrst_geqth", 8'(GEQTH), 8'd0);
    chk("mrst_dout", DATA_OUT, 8'h00);
    tick();
    chk("mrst_pend", DATA_OUT, 8'h00);
    // read in the same edge as the first write is ignored
    DATA_IN = 8'h3C; WRB = 1'b0; RDB = 1'b0; tick(); WRB = 1'b1; RDB = 1'b1;
    chk("same_edge_empty", 8'(EMPTY), 8'd0);
    chk("same_edge_dout", DATA_OUT, 8'h00);
    RDB = 1'b0; tick(); RDB = 1'b1; tick();
    chk("same_edge_rd", DATA_OUT, 8'h3C);
    chk("same_edge_done", 8'(EMPTY), 8'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
